// File: rtl/edge_pkg.sv
// edge_pkg: edge-mode encodings and counter sizing shared by the debounce blocks.
package edge_pkg;
    localparam logic [1:0] EDGE_RISE = 2'b00;
    localparam logic [1:0] EDGE_FALL = 2'b01;
    localparam logic [1:0] EDGE_BOTH = 2'b10;
    localparam logic [1:0] EDGE_NONE = 2'b11;
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/debounce_edge_detect_if.sv
// debounce_edge_detect_if: pin-side inputs and debounced outputs of the debouncer.
interface debounce_edge_detect_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] in_raw;
    logic [1:0]       edge_mode;
    logic [WIDTH-1:0] flag_clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] flags;
    modport master (output in_raw, edge_mode, flag_clr, input level, pulse, flags);
    modport slave  (input in_raw, edge_mode, flag_clr, output level, pulse, flags);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: synchronise, polarity-normalise and debounce one pin,
// producing its level, a mode-qualified edge pulse and a sticky flag.
module debounce_channel
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_raw,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    output logic       o_level,
    output logic       o_pulse,
    output logic       o_flag
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] MAX = CW'(DEBOUNCE_CYCLES - 1);
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level, r_pulse, r_flag;
    logic                   w_norm, w_toggle, w_pulse;
    always_comb begin
        w_norm   = r_sync[SYNC_STAGES-1] ^ 1'(ACTIVE_LOW);
        w_toggle = (w_norm != r_level) && (r_cnt == MAX);
        w_pulse  = w_toggle && (i_mode != EDGE_NONE) &&
                   (i_mode == EDGE_BOTH || i_mode == (w_norm ? EDGE_RISE : EDGE_FALL));
    end
    // any cycle matching the current level restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= {SYNC_STAGES{1'(ACTIVE_LOW)}};
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_cnt   <= (w_norm == r_level || w_toggle) ? '0 : r_cnt + 1'b1;
            r_level <= w_toggle ? w_norm : r_level;
            r_pulse <= w_pulse;
            r_flag  <= (r_flag & ~i_clr) | w_pulse;
        end
    end
    assign o_level = r_level;
    assign o_pulse = r_pulse;
    assign o_flag  = r_flag;
endmodule

// File: rtl/debounce_edge_detect.sv
// debounce_edge_detect: WIDTH independent debounce channels sharing one edge mode.
module debounce_edge_detect
    import edge_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input logic clk,
    input logic rst,
    debounce_edge_detect_if.slave bus
);
    logic [WIDTH-1:0] w_level, w_pulse, w_flags;
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("debounce_edge_detect: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (bus.in_raw[i]),
            .i_mode (bus.edge_mode),
            .i_clr  (bus.flag_clr[i]),
            .o_level(w_level[i]),
            .o_pulse(w_pulse[i]),
            .o_flag (w_flags[i])
        );
    end
    assign bus.level = w_level;
    assign bus.pulse = w_pulse;
    assign bus.flags = w_flags;
endmodule
